pe_array_ctrl: RTL and testbench

- Sequencer for one column-group of the binary-serial systolic PE array.
- Drives the border-PE control inputs (en_i, clr_i, en_w, clr_w, en_o, clr_o, idx) through four phases:
  - clear all PE registers;
  - shift weights in;
  - stream k_len input vectors at IWIDTH cycles per bit-serial MAC;
  - drain the skewed pipeline.
- Provides a start/busy/done handshake to the tile scheduler and vector/bit indices to the ifm/weight feeders.

---
 rtl/pe_array_ctrl_if.sv | 34 +++
 rtl/pe_array_ctrl.sv | 155 +++++++++++++++
 tb/tb_pe_array_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pe_array_ctrl_if.sv
// Scheduler <-> column-group sequencer bundle: start/k_len request, busy/done
// status, border-PE controls and feeder addresses.
interface pe_array_ctrl_if #(
  parameter int IDEPTH = 3,
  parameter int KWIDTH = 8
);
  logic              start;
  logic [KWIDTH-1:0] k_len;
  logic              busy;
  logic              done;
  logic              en_i;
  logic              clr_i;
  logic              en_w;
  logic              clr_w;
  logic              en_o;
  logic              clr_o;
  logic [IDEPTH-1:0] idx;
  logic [KWIDTH-1:0] vec_idx;
  logic [IDEPTH+1:0] w_idx;

  // tile scheduler / feeders side
  modport master (
    output start, k_len,
    input  busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o,
           idx, vec_idx, w_idx
  );

  // sequencer side
  modport slave (
    input  start, k_len,
    output busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o,
           idx, vec_idx, w_idx
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Column-group sequencer for the bit-serial systolic PE array.
// Phases: clear -> weight shift -> k_len bit-serial MACs -> drain -> done.
// Every output is a flop; the next value is decoded from the next state so
// the outputs line up with the state they describe.
module pe_array_ctrl #(
  parameter int IWIDTH    = 8,
  parameter int IDEPTH    = 3,
  parameter int ROWS      = 4,
  parameter int KWIDTH    = 8,
  parameter int DRAIN_CYC = 9
) (
  input  logic clk,
  input  logic rst,
  pe_array_ctrl_if.slave bus
);

  localparam int WW = IDEPTH + 2;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [IDEPTH-1:0] IDX_LAST = IDEPTH'(IWIDTH - 1);
  localparam logic [WW-1:0]     W_LAST   = WW'(ROWS - 1);
  localparam logic [DW-1:0]     D_LAST   = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WLOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [KWIDTH-1:0] k_lat, k_lat_n;
  logic [IDEPTH-1:0] idx_q, idx_n;
  logic [KWIDTH-1:0] vec_q, vec_n;
  logic [WW-1:0]     w_q, w_n;
  logic [DW-1:0]     dcnt, dcnt_n;

  logic busy_q, busy_n;
  logic done_q, done_n;
  logic clr_q, clr_n;
  logic en_w_q, en_w_n;
  logic en_i_q, en_i_n;
  logic en_o_q, en_o_n;

  // State register plus all counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      k_lat  <= '0;
      idx_q  <= '0;
      vec_q  <= '0;
      w_q    <= '0;
      dcnt   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      en_w_q <= 1'b0;
      en_i_q <= 1'b0;
      en_o_q <= 1'b0;
    end else begin
      state  <= state_n;
      k_lat  <= k_lat_n;
      idx_q  <= idx_n;
      vec_q  <= vec_n;
      w_q    <= w_n;
      dcnt   <= dcnt_n;
      busy_q <= busy_n;
      done_q <= done_n;
      clr_q  <= clr_n;
      en_w_q <= en_w_n;
      en_i_q <= en_i_n;
      en_o_q <= en_o_n;
    end
  end

  // Next state, counter sequencing and next-output decode.
  // Counters default to 0 so they are parked outside their own phase and
  // return to 0 on the phase exit.
  always_comb begin
    state_n = state;
    k_lat_n = k_lat;
    idx_n   = '0;
    vec_n   = '0;
    w_n     = '0;
    dcnt_n  = '0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_CLR;
          k_lat_n = bus.k_len;
        end
      end

      S_CLR: state_n = S_WLOAD;

      S_WLOAD: begin
        if (w_q == W_LAST)
          state_n = (k_lat != '0) ? S_COMPUTE : S_DRAIN;
        else
          w_n = w_q + WW'(1);
      end

      S_COMPUTE: begin
        vec_n = vec_q;
        if (idx_q == IDX_LAST) begin
          // k_lat is nonzero here, so k_lat-1 cannot underflow and the
          // compare never needs vec_idx to count past k_len-1.
          if (vec_q == k_lat - KWIDTH'(1)) begin
            state_n = S_DRAIN;
            vec_n   = '0;
          end else begin
            vec_n = vec_q + KWIDTH'(1);
          end
        end else begin
          idx_n = idx_q + IDEPTH'(1);
        end
      end

      S_DRAIN: begin
        if (dcnt == D_LAST)
          state_n = S_DONE;
        else
          dcnt_n = dcnt + DW'(1);
      end

      S_DONE: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
    clr_n  = (state_n == S_CLR);
    en_w_n = (state_n == S_WLOAD);
    // new ifm word at bit 0, product accumulated on the last bit
    en_i_n = (state_n == S_COMPUTE) && (idx_n == '0);
    en_o_n = (state_n == S_COMPUTE) && (idx_n == IDX_LAST);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.clr_i   = clr_q;
  assign bus.clr_w   = clr_q;
  assign bus.clr_o   = clr_q;
  assign bus.en_w    = en_w_q;
  assign bus.en_i    = en_i_q;
  assign bus.en_o    = en_o_q;
  assign bus.idx     = idx_q;
  assign bus.vec_idx = vec_q;
  assign bus.w_idx   = w_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: two instances (default config, and ROWS=1 /
// DRAIN_CYC=1). Expected outputs come from a cycle-offset timeline model.
module tb_pe_array_ctrl;
  localparam int IW = 8;
  localparam int ID = 3;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_array_ctrl_if #(.IDEPTH(ID), .KWIDTH(KW)) if0 ();
  pe_array_ctrl_if #(.IDEPTH(ID), .KWIDTH(KW)) if1 ();

  pe_array_ctrl #(.IWIDTH(IW), .IDEPTH(ID), .ROWS(4), .KWIDTH(KW), .DRAIN_CYC(9))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pe_array_ctrl #(.IWIDTH(IW), .IDEPTH(ID), .ROWS(1), .KWIDTH(KW), .DRAIN_CYC(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  // {busy,done,en_i,clr_i,en_w,clr_w,en_o,clr_o,idx[3],vec_idx[8],w_idx[5]}
  function automatic logic [23:0] obs(input int sel);
    if (sel == 0)
      return {if0.busy, if0.done, if0.en_i, if0.clr_i, if0.en_w, if0.clr_w,
              if0.en_o, if0.clr_o, if0.idx, if0.vec_idx, if0.w_idx};
    return {if1.busy, if1.done, if1.en_i, if1.clr_i, if1.en_w, if1.clr_w,
            if1.en_o, if1.clr_o, if1.idx, if1.vec_idx, if1.w_idx};
  endfunction

  // Expected outputs c cycles after the accepting edge, from the phase timeline:
  // clear at 1, weights 2..rows+1, k*IW compute cycles, drain, done.
  function automatic logic [23:0] model(input int c, input int k, input int rows, input int drain);
    int cs = rows + 2;
    int ce = cs + k * IW;
    int dn = ce + drain;
    logic b, d, ei, cl, ew, eo;
    logic [2:0] ix;
    logic [7:0] v;
    logic [4:0] w;
    b = 0; d = 0; ei = 0; cl = 0; ew = 0; eo = 0; ix = 0; v = 0; w = 0;
    if (c >= 1 && c <= dn) b = 1;
    if (c == dn) d = 1;
    if (c == 1) cl = 1;
    if (c >= 2 && c < cs) begin ew = 1; w = 5'(c - 2); end
    if (c >= cs && c < ce) begin
      ix = 3'((c - cs) % IW);
      v  = 8'((c - cs) / IW);
      ei = (ix == 0);
      eo = (ix == IW - 1);
    end
    return {b, d, ei, cl, ew, cl, eo, cl, ix, v, w};
  endfunction

  task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] k);
    if (sel == 0) begin if0.start = s; if0.k_len = k; end
    else          begin if1.start = s; if1.k_len = k; end
  endtask

  task automatic drive_start(input int sel, input logic s);
    if (sel == 0) if0.start = s; else if1.start = s;
  endtask

  // Called #1 after the accepting edge. Checks cycles 1..last; the last
  // default cycle is the IDLE cycle after done. noise scrambles start/k_len
  // while busy (must be ignored); hold is start's value in that IDLE cycle.
  task automatic check_run(input int sel, input int k, input int rows, input int drain,
                           input bit noise, input bit hold, input int maxc);
    int dn   = rows + 2 + k * IW + drain;
    int last = (maxc > 0) ? maxc : dn + 1;
    int ni = 0;
    int no = 0;
    logic [23:0] o;
    for (int c = 1; c <= last; c++) begin
      o = obs(sel);
      chk($sformatf("dut%0d k=%0d c=%0d", sel, k, c), o, model(c, k, rows, drain));
      ni += int'(o[21]);
      no += int'(o[17]);
      if (noise && c <= dn)
        drive(sel, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      else if (c == dn + 1)
        drive_start(sel, hold);
      @(posedge clk); #1;
    end
    if (maxc == 0) begin
      chk($sformatf("dut%0d k=%0d en_i count", sel, k), 24'(ni), 24'(k));
      chk($sformatf("dut%0d k=%0d en_o count", sel, k), 24'(no), 24'(k));
    end
  endtask

  task automatic start_run(input int sel, input int k);
    drive(sel, 1'b1, 8'(k));
    @(posedge clk); #1;
    drive_start(sel, 1'b0);
  endtask

  initial begin
    int k, sel, cs;
    drive(0, 1'b1, 8'd7);
    drive(1, 1'b1, 8'd7);

    // reset with start asserted: everything stays 0
    repeat (3) @(posedge clk);
    #1;
    chk("reset dut0", obs(0), 24'h0);
    chk("reset dut1", obs(1), 24'h0);
    drive(0, 1'b0, 8'd0);
    drive(1, 1'b0, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle dut0", obs(0), 24'h0);

    // default config, k_len=2, then k_len=0
    start_run(0, 2);
    check_run(0, 2, 4, 9, 1'b0, 1'b0, 0);
    start_run(0, 0);
    check_run(0, 0, 4, 9, 1'b0, 1'b0, 0);

    // start held high, k_len changed to 5 while run 1 is busy
    drive(0, 1'b1, 8'd1);
    @(posedge clk); #1;
    drive(0, 1'b1, 8'd5);
    check_run(0, 1, 4, 9, 1'b0, 1'b1, 0);
    drive_start(0, 1'b0);
    check_run(0, 5, 4, 9, 1'b0, 1'b0, 0);

    // reset in COMPUTE at vec_idx=1, idx=3
    start_run(0, 3);
    cs = 4 + 2;
    check_run(0, 3, 4, 9, 1'b0, 1'b0, cs + IW + 2);
    chk("pre-reset point", obs(0), model(cs + IW + 3, 3, 4, 9));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-run reset", obs(0), 24'h0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("post-reset idle %0d", i), obs(0), 24'h0);
      @(posedge clk); #1;
    end
    start_run(0, 1);
    check_run(0, 1, 4, 9, 1'b0, 1'b0, 0);

    // small config
    start_run(1, 1);
    check_run(1, 1, 1, 1, 1'b0, 1'b0, 0);

    // max k_len with noisy start/k_len while busy
    start_run(0, 255);
    check_run(0, 255, 4, 9, 1'b1, 1'b0, 0);

    // randomized runs with idle gaps
    for (int r = 0; r < 10; r++) begin
      sel = int'($urandom_range(0, 1));
      k   = int'($urandom_range(0, 6));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        chk($sformatf("gap dut%0d", sel), obs(sel), 24'h0);
        @(posedge clk); #1;
      end
      start_run(sel, k);
      if (sel == 0) check_run(0, k, 4, 9, 1'b1, 1'b0, 0);
      else          check_run(1, k, 1, 1, 1'b1, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
